// File: rtl/conv_pkg.sv
// Shared defaults and packing helpers for the KxK multi-channel window datapath.
package conv_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int K_DEF          = 3;
    localparam int CH_DEF         = 1;

    function automatic int win_bits(input int k, input int ch, input int dw);
        return k * k * ch * dw;
    endfunction

    // Element (r,c,ch) lives at ((r*K+c)*CH+ch)*DW; geometry defaults to the 3x3x1x8 case.
    function automatic int elem_off(input int r, input int c, input int ch,
                                    input int k  = K_DEF,
                                    input int nch = CH_DEF,
                                    input int dw = DATA_WIDTH_DEF);
        return ((r * k + c) * nch + ch) * dw;
    endfunction

endpackage

// File: rtl/conv_window_fifo_ctrl.sv
// Pointer/occupancy control for the window FIFO: handshake decode, flush and consumed-window count.
module conv_window_fifo_ctrl
    import conv_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 input_ready,
    output logic                 out_valid,
    output logic                 push,
    output logic [PW-1:0]        wr_ptr,
    output logic [PW-1:0]        rd_ptr,
    output logic [CNT_WIDTH-1:0] win_count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count;
    logic          pop;

    // rst gates ready so upstream sees no space while the buffer is held in reset.
    assign input_ready = rst & (count != FULL);
    assign out_valid   = (count != '0);
    assign push        = input_valid & input_ready & ~flush;
    assign pop         = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            win_count <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            win_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                win_count <= win_count + CNT_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_window_input_fifo.sv
// Window input stage: zero-pads masked positions, buffers DEPTH windows, presents the head to compute.
module conv_window_input_fifo
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int K          = K_DEF,
    parameter int CH         = CH_DEF,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int WB = win_bits(K, CH, DATA_WIDTH),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic [WB-1:0]        in_data,
    input  logic [K*K-1:0]       pad_mask,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WB-1:0]        out_data,
    output logic [CNT_WIDTH-1:0] win_count
);

    logic [WB-1:0]            masked;
    logic [DEPTH-1:0][WB-1:0] mem;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic                     push;

    conv_window_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .input_valid (input_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .input_ready (input_ready),
        .out_valid   (out_valid),
        .push        (push),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .win_count   (win_count)
    );

    // One mask bit covers every channel of its position.
    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            for (genvar ch = 0; ch < CH; ch++) begin : g_ch
                localparam int OFF = elem_off(r, c, ch, K, CH, DATA_WIDTH);
                assign masked[OFF +: DATA_WIDTH] =
                    pad_mask[r*K + c] ? '0 : in_data[OFF +: DATA_WIDTH];
            end
        end
    end

    // Storage is cleared on reset so out_data reads zero while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem <= '0;
        else if (push)
            mem[wr_ptr] <= masked;
    end

    assign out_data = mem[rd_ptr];

endmodule
